// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant outputs).
interface rr_decode_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with hold limit; grant one cycle after request, all outputs registered.
// No backpressure: an owner keeps the grant while requesting, up to MAX_HOLD cycles when others wait.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_decode_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       others;
    logic             owner_req;
    logic             at_limit;
    logic [2:0]       win_idle;
    logic [2:0]       win_next;

    // 2-to-4 line decoder shared by the mask and the grant output.
    function automatic logic [3:0] decode(input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = 4'b0001;
            2'd1:    d = 4'b0010;
            2'd2:    d = 4'b0100;
            default: d = 4'b1000;
        endcase
        return d;
    endfunction

    // Returns {found, index} of the first set bit at or after start, wrapping 3 -> 0.
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner_req = bus.req[idx_q];
    assign others    = bus.req & ~decode(idx_q);
    assign at_limit  = (cnt_q == HOLD_LAST);
    assign win_idle  = search(bus.req, last_q + 2'd1);
    assign win_next  = search(others, idx_q + 2'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_idle[2]) begin
                    state_d = GRANT;
                    idx_d   = win_idle[1:0];
                    last_d  = win_idle[1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!owner_req || at_limit) begin
                    cnt_d = '0;
                    if (win_next[2]) begin
                        // Release and revoke both hand over without an idle bubble.
                        idx_d  = win_next[1:0];
                        last_d = win_next[1:0];
                        to_d   = owner_req;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus.gnt = valid_q ? decode(idx_q) : 4'b0000;
    end

    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scenario tasks plus randomized traffic, each compared against an integer-level
// model of the round-robin/hold-limit rules.
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int BOUND    = 3 * MAX_HOLD + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    rr_decode_arbiter_if bus ();

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: owner -1 means no grant; held = cycles the grant has been visible.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    bit m_to    = 1'b0;

    function automatic int next_from(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input bit do_rst);
        logic [3:0] oth;
        int w;
        if (do_rst) begin
            m_owner = -1; m_held = 0; m_last = 3; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = next_from(r, m_last + 1);
            if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            w = next_from(oth, m_owner + 1);
            if (!r[m_owner]) begin
                if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
                else m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                if (w >= 0) begin m_owner = w; m_last = w; m_to = 1'b1; end
                m_held = 1;
            end else begin
                m_held = m_held + 1;
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        logic [1:0] idx;
        logic [3:0] g;
        idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {(m_owner >= 0), idx, g, m_to};
    endfunction

    logic [7:0] obs;
    assign obs = {bus.gnt_valid, bus.gnt_idx, bus.gnt, bus.timeout};

    // Applies one clock of stimulus to DUT and model; sampling happens 1 time unit after the edge.
    task automatic drive(input logic [3:0] r, input bit do_rst);
        bus.req = r;
        rst     = do_rst;
        @(posedge clk);
        model_edge(r, do_rst);
        #1;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b1);
        drive(4'b1111, 1'b1);
        vectors++;
        if (obs !== model_out())
            $display("FAIL reset_state got %b want %b", obs, model_out());
        if (obs !== model_out()) errors++;
        vectors++;
        if (obs !== 8'b0)
            begin errors++; $display("FAIL reset_zero got %b want 00000000", obs); end
    endtask

    task automatic test_single();
        drive(4'b0000, 1'b1);
        drive(4'b0001, 1'b0);
        vectors++;
        if (obs !== model_out() || bus.gnt !== 4'b0001)
            begin errors++; $display("FAIL single_grant got %b want %b", obs, model_out()); end
        drive(4'b0000, 1'b0);
        vectors++;
        if (obs !== model_out() || bus.gnt_valid !== 1'b0)
            begin errors++; $display("FAIL single_release got %b want %b", obs, model_out()); end
    endtask

    task automatic test_rotation();
        logic [3:0] r;
        int prev = -1;
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 14; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
            drive(r, 1'b0);
            vectors++;
            if (obs !== model_out())
                begin errors++; $display("FAIL rotation cyc %0d got %b want %b", c, obs, model_out()); end
            vectors++;
            if (bus.gnt_valid !== 1'b1)
                begin errors++; $display("FAIL rotation_bubble cyc %0d gnt_valid %b want 1", c, bus.gnt_valid); end
            if (prev >= 0 && int'(bus.gnt_idx) != prev) begin
                vectors++;
                if (int'(bus.gnt_idx) != (prev + 1) % 4)
                    begin errors++; $display("FAIL rotation_order got %0d want %0d", bus.gnt_idx, (prev + 1) % 4); end
            end
            prev = int'(bus.gnt_idx);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 33; c++) begin
            drive(4'b0011, 1'b0);
            vectors++;
            if (obs !== model_out())
                begin errors++; $display("FAIL timeout cyc %0d got %b want %b", c, obs, model_out()); end
            if (bus.timeout === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 4)
            begin errors++; $display("FAIL timeout_count got %0d want 4", pulses); end
    endtask

    task automatic test_lone_hold();
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            drive(4'b0100, 1'b0);
            vectors++;
            if (bus.gnt !== 4'b0100 || bus.timeout !== 1'b0 || obs !== model_out())
                begin errors++; $display("FAIL lone_hold cyc %0d got %b want %b", c, obs, model_out()); end
        end
    endtask

    task automatic test_release_same_cycle();
        drive(4'b0000, 1'b1);
        drive(4'b0100, 1'b0);
        drive(4'b0010, 1'b0);
        vectors++;
        if (bus.gnt !== 4'b0010 || obs !== model_out())
            begin errors++; $display("FAIL release_handover got %b want %b", obs, model_out()); end
        // With last_idx=1, the search after owner 1 releases starts at 2.
        drive(4'b1101, 1'b0);
        vectors++;
        if (bus.gnt !== 4'b0100 || obs !== model_out())
            begin errors++; $display("FAIL release_last_idx got %b want %b", obs, model_out()); end
    endtask

    task automatic test_reset_mid();
        drive(4'b0000, 1'b1);
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b0);
        vectors++;
        if (bus.gnt !== 4'b1000)
            begin errors++; $display("FAIL mid_pre got %b want 1000", bus.gnt); end
        drive(4'b1001, 1'b1);
        vectors++;
        if (obs !== 8'b0 || obs !== model_out())
            begin errors++; $display("FAIL mid_reset got %b want 00000000", obs); end
        drive(4'b1001, 1'b0);
        vectors++;
        if (bus.gnt !== 4'b0001 || obs !== model_out())
            begin errors++; $display("FAIL mid_after got %b want %b", obs, model_out()); end
    endtask

    task automatic test_random();
        logic [3:0] r = 4'b0000;
        bit rs;
        int waitc [4] = '{0, 0, 0, 0};
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            rs = ($urandom_range(199) == 0);
            drive(r, rs);
            vectors++;
            if (obs !== model_out())
                begin errors++; $display("FAIL random cyc %0d req %b got %b want %b", c, r, obs, model_out()); end
            for (int i = 0; i < 4; i++) begin
                if (rs || !r[i] || bus.gnt[i]) waitc[i] = 0;
                else waitc[i] = waitc[i] + 1;
                vectors++;
                if (waitc[i] > BOUND)
                    begin errors++; $display("FAIL starvation req %0d waited %0d want <= %0d", i, waitc[i], BOUND); end
            end
        end
    endtask

    initial begin
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_lone_hold();
        test_release_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Four-requester round-robin arbiter for a shared resource addressed through the team's 2-to-4 line decoder.
- Registers a 2-bit grant index and drives the one-hot grant from it through the same decode: idx 0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000.
- Holds a grant while the owner keeps requesting. A hold-limit counter stops any one requester from starving the others.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one grant may last while other requests are pending. Legal range 2..256.
- CNT_W, default 8: hold counter width. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i]=1 means requester i wants the resource.
- gnt  output  4  one-hot grant, decoded from gnt_idx and qualified by gnt_valid; all zeros when no grant.
- gnt_idx  output  2  index of the current owner, registered.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse in the cycle after a grant is revoked by the hold limit.

Behaviour:
- All outputs are registered; gnt is a pure decode of the registered gnt_idx AND gnt_valid.
- Reset (rst=1 at a clock edge; overrides everything, including mid-grant):
  - state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - last_idx=11, so requester 0 has top priority first.
  - hold_cnt=0.
- Priority search: starting from (last_idx+1) mod 4 and wrapping 3->0, the first index with the relevant req bit set wins.
- State IDLE:
  - If req != 0000 at edge k: gnt_idx=winner, gnt_valid=1, last_idx=winner, hold_cnt=0, go to GRANT.
  - gnt is visible after edge k, i.e. one-cycle latency.
  - Otherwise stay in IDLE with all outputs 0.
- State GRANT, owner o = gnt_idx, others = req with bit o masked:
  - (a) req[o]=0 (release): if others != 0, grant the next winner searched from o+1, with no idle bubble, hold_cnt=0. Otherwise gnt_valid=0 and go to IDLE.
  - (b) req[o]=1 and hold_cnt == MAX_HOLD-1 and others != 0: revoke and grant the next winner of others, hold_cnt=0, pulse timeout=1 for one cycle.
  - (c) req[o]=1 and hold_cnt == MAX_HOLD-1 and others == 0: keep the grant, hold_cnt=0, no timeout pulse.
  - (d) Otherwise keep the grant and increment hold_cnt. It never exceeds MAX_HOLD-1.
- last_idx updates on every new grant, including a switch without a bubble.
- A request arriving in the same cycle as a release is eligible in that cycle's search.
- A releasing owner that re-raises its request later is served only after the others in rotation order.
- gnt is never multi-hot. gnt=0000 exactly when gnt_valid=0.
- A grant never changes owner except via release, timeout, or reset.
- Invariants for verification:
  - gnt == (gnt_valid ? 1<<gnt_idx : 0) in every cycle.
  - A continuously asserted req[i] is granted within 3*MAX_HOLD+3 cycles.

Test Plan:
- Reset then req=0001 held: gnt=0001 and gnt_idx=0 one cycle after req. Drop req: gnt=0000, gnt_valid=0 on the next cycle.
- req=1111 held, each owner drops its bit for one cycle after being granted 2 cycles: grant order 0001 -> 0010 -> 0100 -> 1000 -> 0001 with no idle cycle between grants.
- MAX_HOLD=8, req=0011 held constantly: gnt=0001 for exactly 8 cycles, timeout pulses, gnt=0010 for 8 cycles, then back to 0001.
- req=0100 alone held for 20 cycles with MAX_HOLD=8: gnt=0100 throughout, timeout never asserts.
- Owner 2 releases in the same cycle req[1] rises (req=0010): next grant is 0010 with no bubble, and last_idx=1.
- Assert rst mid-grant (gnt=1000): next cycle gnt=0000, gnt_valid=0, timeout=0. With req=1001 afterwards, requester 0 wins (last_idx reset to 3).
